uart_fifo_bridge: RTL and testbench
===================================

// Module: uart_fifo_bridge
// PURPOSE
//  Parametrised full-duplex UART with built-in 16x-oversampled TX/RX engines, TX and RX FIFOs,
//  configurable frame format (data bits, parity, stop bits) and per-byte error flags.
//  Sits between the CPU-side serial device / testbench and the board pins; successor of the
//  single-byte, unbuffered, 8N1-only UART model.
// PARAMETERS
//  CLK_FREQ    80_000_000  input clock frequency, Hz
//  BAUD        1_152_000   line rate, bit/s
//  OVERSAMPLE  16          ticks per bit (power of 2, >=8)
//  DATA_BITS   8           payload bits per frame, 5..8
//  PARITY      0           0 none, 1 even, 2 odd
//  STOP_BITS   1           1 or 2
//  TX_DEPTH    16          TX FIFO entries (power of 2, >=2)
//  RX_DEPTH    16          RX FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  asynchronous reset, active high
//  rxd            in   1                  serial input (async to clk)
//  txd            out  1                  serial output
//  tx_valid       in   1                  push request
//  tx_data        in   DATA_BITS          byte to send
//  tx_ready       out  1                  TX FIFO not full
//  tx_idle        out  1                  TX FIFO empty and TX FSM in IDLE
//  rx_valid       out  1                  RX FIFO head valid
//  rx_data        out  DATA_BITS          RX FIFO head data
//  rx_parity_err  out  1                  head byte had parity mismatch (qualified by rx_valid)
//  rx_frame_err   out  1                  head byte had stop bit sampled 0 (qualified by rx_valid)
//  rx_ready       in   1                  pop request
//  rx_overrun     out  1                  1-cycle pulse: received byte dropped, RX FIFO full
//  tx_level       out  $clog2(TX_DEPTH)+1 TX FIFO occupancy
//  rx_level       out  $clog2(RX_DEPTH)+1 RX FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): txd=1, tx_ready=1, tx_idle=1, rx_valid=0, both errs=0,
//   rx_overrun=0, levels=0; FSMs IDLE, FIFOs emptied, rxd synchroniser preset to 1.
//   Mid-frame reset abandons the frame; txd returns to 1 immediately.
//  Tick: divisor DIV=round(CLK_FREQ/(BAUD*OVERSAMPLE)), min 1; free-running counter, 1-clk pulse.
//  Handshakes: push when tx_valid&&tx_ready; pop when rx_valid&&rx_ready; RX FIFO is FWFT.
//  Simultaneous push+pop on a full FIFO: both succeed, level unchanged. On empty: push only.
//  TX FSM IDLE->START->DATA->PARITY(if PARITY!=0)->STOP->IDLE. IDLE pops FIFO head when non-empty;
//   each bit lasts exactly OVERSAMPLE ticks; LSB first; even parity = ^data, odd = ~^data;
//   STOP holds txd=1 for STOP_BITS bits. Back-to-back bytes with no idle gap.
//  RX path: rxd through 2-flop synchroniser. FSM IDLE->START->DATA->PARITY->STOP->(BREAK)->IDLE.
//   IDLE: falling edge starts tick count. START: sample at tick OVERSAMPLE/2; if 1 -> glitch,
//   return IDLE, nothing pushed. Later bits sampled at mid-bit (every OVERSAMPLE ticks).
//   Only the first stop bit is checked. At STOP sample, push {frame_err,parity_err,data};
//   if FIFO full and no pop that cycle -> drop byte, pulse rx_overrun. FIFO contents untouched.
//   Stop sampled 0 with data all-zero (break): push with frame_err, then BREAK state waits
//   for rxd==1 before IDLE.
//  rx_valid rises 2 clk after the stop-bit sample tick (push reg + FWFT output).
// STRUCTURE
//  Package uart_pkg: parity_e (NONE/EVEN/ODD), tx_state_e, rx_state_e, function
//  uart_div(clk,baud,os). One sub-module: uart_sync_fifo #(WIDTH,DEPTH), instantiated for TX
//  (WIDTH=DATA_BITS) and RX (WIDTH=DATA_BITS+2); FSMs and tick generator inline.
// TESTING  (CLK_FREQ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 -> 16 clk/bit; txd looped to rxd)
//  1. 8N1, push 0xA5 -> txd: 0,1,0,1,0,0,1,0,1,1 each 16 clk; rx_data=0xA5, errs 0, tx_idle back to 1.
//  2. 8E1, push 0x07 -> parity bit 1 on line; force parity bit flipped -> rx_parity_err=1 with 0x07.
//  3. Push 17 bytes while TX busy -> tx_ready low once tx_level=16; 17th not accepted; all 16 received in order.
//  4. rx_ready=0, 17 frames on rxd -> rx_level=16, one rx_overrun pulse, then pops yield frames 1..16.
//  5. rxd low 4 clk then high -> no push; rxd low 20 bit-times -> one 0x00 with frame_err, then idle.
//  6. Assert rst mid-byte on TX and RX -> txd=1 same cycle, levels 0; next 0x3C sent/received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART bridge.
//   parity_e   : frame parity mode (none / even / odd)
//   tx_state_e : transmit FSM states
//   rx_state_e : receive FSM states
//   uart_div   : clocks per oversample tick, rounded, minimum 1
//   parity_bit : parity bit to send for a payload (payload zero-extended to 8 bits)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned q;
    den = 64'(baud) * 64'(os);
    if (den == 64'd0) return 1;
    q = (64'(clk_hz) + den / 64'd2) / den;
    if (q < 64'd1) q = 64'd1;
    return 32'(q);
  endfunction

  // Zero padding does not change the XOR, so narrow payloads may be extended.
  function automatic logic parity_bit(input logic [7:0] d, input parity_e p);
    case (p)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~^d;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (accepted when not full, or when full and popping)
//   pop        : remove head (ignored when empty)
//   pop_data   : current head word
//   full/empty : occupancy flags, level : occupancy count
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write in the same cycle as a read.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;

endmodule

// File: rtl/uart_fifo_bridge.sv
// Full-duplex buffered UART: oversampled TX/RX engines with FIFOs on both sides.
//   clk, rst                     : clock, asynchronous active-high reset
//   rxd / txd                    : serial line in (async) / out
//   tx_valid, tx_data, tx_ready  : push side of the TX FIFO
//   tx_idle                      : nothing queued and transmitter idle
//   rx_valid, rx_data, rx_ready  : FWFT pop side of the RX FIFO
//   rx_parity_err, rx_frame_err  : error flags of the head byte
//   rx_overrun                   : one-cycle pulse when a received byte is dropped
//   tx_level, rx_level           : FIFO occupancies
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 80_000_000,
  parameter int unsigned BAUD       = 1_152_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  output logic                        txd,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_idle,
  output logic                        rx_valid,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  input  logic                        rx_ready,
  output logic                        rx_overrun,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = 4;
  localparam int unsigned RW    = DATA_BITS + 2;
  localparam parity_e     PAR   = parity_e'(2'(PARITY));

  // Reset: asserts immediately, releases two clocks after rst falls.
  logic [1:0] rst_q;
  logic       rst_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];

  // Free-running oversample tick.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_W'(DIV - 1));
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------- transmit ----------------
  logic [DATA_BITS-1:0] txf_data;
  logic                 txf_full, txf_empty, tx_pop;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst_i), .push(tx_valid && !txf_full), .push_data(tx_data),
    .pop(tx_pop), .pop_data(txf_data), .full(txf_full), .empty(txf_empty),
    .level(tx_level)
  );

  tx_state_e            tx_state, tx_state_d;
  logic [OS_W-1:0]      tx_os, tx_os_d;
  logic [BIT_W-1:0]     tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
  logic                 tx_par, tx_par_d, txd_d, tx_bit_end;

  assign tx_bit_end = tick && (tx_os == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_os    <= tx_os_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_par   <= tx_par_d;
      txd      <= txd_d;
    end
  end

  // TX next state; the line level is decoded from the next state so txd is a flop.
  always_comb begin
    tx_state_d = tx_state;
    tx_os_d    = tick ? tx_os + OS_W'(1) : tx_os;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_par_d   = tx_par;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_os_d = '0;
        if (!txf_empty) tx_pop = 1'b1;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_sh_d = tx_sh >> 1;
        if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = (PAR == PAR_NONE) ? TX_STOP : TX_PARITY;
        end else begin
          tx_bit_d = tx_bit + BIT_W'(1);
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit == BIT_W'(STOP_BITS - 1)) begin
          if (!txf_empty) tx_pop = 1'b1;
          else            tx_state_d = TX_IDLE;
        end else begin
          tx_bit_d = tx_bit + BIT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading straight out of STOP keeps consecutive frames gapless.
    if (tx_pop) begin
      tx_sh_d    = txf_data;
      tx_par_d   = parity_bit(8'(txf_data), PAR);
      tx_state_d = TX_START;
      tx_os_d    = '0;
      tx_bit_d   = '0;
    end
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_sh_d[0];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  assign tx_ready = !txf_full;
  assign tx_idle  = txf_empty && (tx_state == TX_IDLE);

  // ---------------- receive ----------------
  logic rx_s1, rx_s2, rx_prev;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_e            rx_state, rx_state_d;
  logic [OS_W-1:0]      rx_os, rx_os_d;
  logic [BIT_W-1:0]     rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic                 rx_perr, rx_perr_d;
  logic                 rx_push_q, rx_push_d;
  logic [RW-1:0]        rx_word_q, rx_word_d;
  logic                 rx_half, rx_bit_end;

  assign rx_half    = tick && (rx_os == OS_W'(OVERSAMPLE / 2 - 1));
  assign rx_bit_end = tick && (rx_os == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_state  <= RX_IDLE;
      rx_os     <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_perr   <= 1'b0;
      rx_push_q <= 1'b0;
      rx_word_q <= '0;
    end else begin
      rx_state  <= rx_state_d;
      rx_os     <= rx_os_d;
      rx_bit    <= rx_bit_d;
      rx_sh     <= rx_sh_d;
      rx_perr   <= rx_perr_d;
      rx_push_q <= rx_push_d;
      rx_word_q <= rx_word_d;
    end
  end

  // RX next state: start bit checked at half-bit, later bits one bit apart (mid-bit).
  always_comb begin
    rx_state_d = rx_state;
    rx_os_d    = tick ? rx_os + OS_W'(1) : rx_os;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_perr_d  = rx_perr;
    rx_push_d  = 1'b0;
    rx_word_d  = rx_word_q;
    case (rx_state)
      RX_IDLE: begin
        rx_os_d   = '0;
        rx_perr_d = 1'b0;
        if (rx_prev && !rx_s2) rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        rx_os_d    = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_sh_d = {rx_s2, rx_sh[DATA_BITS-1:1]};
        if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
          rx_bit_d   = '0;
          rx_state_d = (PAR == PAR_NONE) ? RX_STOP : RX_PARITY;
        end else begin
          rx_bit_d = rx_bit + BIT_W'(1);
        end
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_perr_d  = (rx_s2 != parity_bit(8'(rx_sh), PAR));
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_push_d  = 1'b1;
        rx_word_d  = {!rx_s2, rx_perr, rx_sh};
        // A zero stop bit after an all-zero payload is a line break.
        rx_state_d = (!rx_s2 && (rx_sh == '0)) ? RX_BREAK : RX_IDLE;
      end
      RX_BREAK: if (rx_s2) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  logic [RW-1:0] rxf_data;
  logic          rxf_full, rxf_empty, rx_pop;

  assign rx_pop = rx_ready && !rxf_empty;

  uart_sync_fifo #(.WIDTH(RW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst_i), .push(rx_push_q), .push_data(rx_word_q),
    .pop(rx_pop), .pop_data(rxf_data), .full(rxf_full), .empty(rxf_empty),
    .level(rx_level)
  );

  // Dropped byte: FIFO full and not being drained in the push cycle.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) rx_overrun <= 1'b0;
    else       rx_overrun <= rx_push_q && rxf_full && !rx_pop;
  end

  assign rx_valid      = !rxf_empty;
  assign rx_data       = rxf_data[DATA_BITS-1:0];
  assign rx_parity_err = rx_valid && rxf_data[DATA_BITS];
  assign rx_frame_err  = rx_valid && rxf_data[DATA_BITS+1];

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: an 8N1 instance (loopback or bench-driven line)
// and an 8E1 instance in loopback with an optional parity-bit inversion on the line.
module tb_uart_fifo_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8N1 instance
  logic       a_loop, a_line, a_rxd, a_txd;
  logic       a_tx_valid, a_tx_ready, a_tx_idle;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_ready, a_rx_overrun;
  logic [4:0] a_tx_level, a_rx_level;
  assign a_rxd = a_loop ? a_txd : a_line;

  // 8E1 instance
  logic       e_flip, e_rxd, e_txd;
  logic       e_tx_valid, e_tx_ready, e_tx_idle;
  logic [7:0] e_tx_data, e_rx_data;
  logic       e_rx_valid, e_rx_perr, e_rx_ferr, e_rx_ready, e_rx_overrun;
  logic [4:0] e_tx_level, e_rx_level;
  assign e_rxd = e_txd ^ e_flip;

  uart_fifo_bridge #(
    .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .rxd(a_rxd), .txd(a_txd),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx_idle(a_tx_idle),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_parity_err(a_rx_perr),
    .rx_frame_err(a_rx_ferr), .rx_ready(a_rx_ready), .rx_overrun(a_rx_overrun),
    .tx_level(a_tx_level), .rx_level(a_rx_level)
  );

  uart_fifo_bridge #(
    .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16)
  ) dut_e (
    .clk(clk), .rst(rst), .rxd(e_rxd), .txd(e_txd),
    .tx_valid(e_tx_valid), .tx_data(e_tx_data), .tx_ready(e_tx_ready), .tx_idle(e_tx_idle),
    .rx_valid(e_rx_valid), .rx_data(e_rx_data), .rx_parity_err(e_rx_perr),
    .rx_frame_err(e_rx_ferr), .rx_ready(e_rx_ready), .rx_overrun(e_rx_overrun),
    .tx_level(e_tx_level), .rx_level(e_rx_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Overrun pulses are one clock wide, so each is seen at exactly one falling edge.
  int   ovr_cnt;
  logic ovr_clr;
  always @(negedge clk) ovr_cnt <= ovr_clr ? 0 : ovr_cnt + (a_rx_overrun ? 1 : 0);

  typedef struct packed {
    logic [7:0] data;
    logic       flip;
    logic       exp_pbit;
    logic       exp_perr;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] d);
    if (sel) begin e_tx_data = d; e_tx_valid = 1'b1; end
    else     begin a_tx_data = d; a_tx_valid = 1'b1; end
    @(negedge clk);
    a_tx_valid = 1'b0;
    e_tx_valid = 1'b0;
  endtask

  task automatic wait_txd_low(input bit sel, input string nm);
    int n;
    n = 0;
    while (((sel ? e_txd : a_txd) !== 1'b0) && n < 50) begin @(negedge clk); n++; end
    check({nm, "_start"}, 32'(sel ? e_txd : a_txd), 32'd0);
  endtask

  task automatic expect_rx(input bit sel, input logic [7:0] d, input logic perr,
                           input logic ferr, input string nm);
    int n;
    n = 0;
    while (((sel ? e_rx_valid : a_rx_valid) !== 1'b1) && n < 600) begin @(negedge clk); n++; end
    check({nm, "_valid"}, 32'(sel ? e_rx_valid : a_rx_valid), 32'd1);
    if (n < 600) begin
      check({nm, "_data"}, 32'(sel ? e_rx_data : a_rx_data), 32'(d));
      check({nm, "_perr"}, 32'(sel ? e_rx_perr : a_rx_perr), 32'(perr));
      check({nm, "_ferr"}, 32'(sel ? e_rx_ferr : a_rx_ferr), 32'(ferr));
      if (sel) e_rx_ready = 1'b1; else a_rx_ready = 1'b1;
      @(negedge clk);
      a_rx_ready = 1'b0;
      e_rx_ready = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    a_line = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      a_line = d[b];
      repeat (16) @(negedge clk);
    end
    a_line = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic exp1 [10];
    int   bad;

    exp1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    //            data   flip  pbit  perr
    vecs[0] = '{8'h07, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'hD6, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; ovr_clr = 1'b1;
    a_loop = 1'b1; a_line = 1'b1; a_tx_valid = 1'b0; a_tx_data = '0; a_rx_ready = 1'b0;
    e_flip = 1'b0; e_tx_valid = 1'b0; e_tx_data = '0; e_rx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd",      32'(a_txd),        32'd1);
    check("rst_tx_ready", 32'(a_tx_ready),   32'd1);
    check("rst_tx_idle",  32'(a_tx_idle),    32'd1);
    check("rst_rx_valid", 32'(a_rx_valid),   32'd0);
    check("rst_perr",     32'(a_rx_perr),    32'd0);
    check("rst_ferr",     32'(a_rx_ferr),    32'd0);
    check("rst_overrun",  32'(a_rx_overrun), 32'd0);
    check("rst_tx_level", 32'(a_tx_level),   32'd0);
    check("rst_rx_level", 32'(a_rx_level),   32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    ovr_clr = 1'b0;

    // 8N1 0xA5: every line bit held for 16 clocks
    push(1'b0, 8'hA5);
    wait_txd_low(1'b0, "t1");
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        if (a_txd !== exp1[i]) bad++;
        @(negedge clk);
      end
      check($sformatf("t1_line_bit%0d_bad_samples", i), 32'(bad), 32'd0);
    end
    expect_rx(1'b0, 8'hA5, 1'b0, 1'b0, "t1_rx");
    check("t1_tx_idle", 32'(a_tx_idle), 32'd1);

    // 8E1 table: parity bit on the line, optionally inverted before the receiver
    for (int v = 0; v < 8; v++) begin
      push(1'b1, vecs[v].data);
      wait_txd_low(1'b1, $sformatf("tab%0d", v));
      for (int k = 0; k < 176; k++) begin
        if (k == 144) e_flip = vecs[v].flip;
        if (k == 152) check($sformatf("tab%0d_pbit", v), 32'(e_txd), 32'(vecs[v].exp_pbit));
        if (k == 160) e_flip = 1'b0;
        @(negedge clk);
      end
      expect_rx(1'b1, vecs[v].data, vecs[v].exp_perr, 1'b0, $sformatf("tab%0d_rx", v));
    end

    // TX FIFO fills while a frame is in flight; a 17th push is held off
    push(1'b0, 8'h55);
    repeat (3) @(negedge clk);
    check("t3_level_after_load", 32'(a_tx_level), 32'd0);
    for (int i = 0; i < 16; i++) begin
      a_tx_data = 8'(8'h60 + i); a_tx_valid = 1'b1;
      @(negedge clk);
    end
    a_tx_data = 8'h70;
    check("t3_level_full", 32'(a_tx_level), 32'd16);
    check("t3_ready_low",  32'(a_tx_ready), 32'd0);
    repeat (5) @(negedge clk);
    check("t3_level_held", 32'(a_tx_level), 32'd16);
    a_tx_valid = 1'b0;
    expect_rx(1'b0, 8'h55, 1'b0, 1'b0, "t3_rx_first");
    for (int i = 0; i < 16; i++)
      expect_rx(1'b0, 8'(8'h60 + i), 1'b0, 1'b0, $sformatf("t3_rx%0d", i));
    repeat (200) @(negedge clk);
    check("t3_no_extra", 32'(a_rx_valid), 32'd0);
    check("t3_tx_idle",  32'(a_tx_idle),  32'd1);

    // RX overrun: 17 frames with nobody popping
    a_loop = 1'b0; a_line = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 17; i++) send_frame(8'(8'h10 + i));
    repeat (20) @(negedge clk);
    check("t4_rx_level", 32'(a_rx_level), 32'd16);
    check("t4_overruns", 32'(ovr_cnt),    32'd1);
    for (int i = 1; i <= 16; i++)
      expect_rx(1'b0, 8'(8'h10 + i), 1'b0, 1'b0, $sformatf("t4_rx%0d", i));
    check("t4_drained", 32'(a_rx_valid), 32'd0);

    // Start-bit glitch, then a long break, then a normal frame
    a_line = 1'b0;
    repeat (4) @(negedge clk);
    a_line = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_glitch_level", 32'(a_rx_level), 32'd0);
    a_line = 1'b0;
    repeat (320) @(negedge clk);
    a_line = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_break_level", 32'(a_rx_level), 32'd1);
    expect_rx(1'b0, 8'h00, 1'b0, 1'b1, "t5_break");
    repeat (100) @(negedge clk);
    check("t5_after_break", 32'(a_rx_valid), 32'd0);
    send_frame(8'h5A);
    expect_rx(1'b0, 8'h5A, 1'b0, 1'b0, "t5_resume");

    // Reset in the middle of a frame with bytes still queued
    a_loop = 1'b1;
    repeat (20) @(negedge clk);
    push(1'b0, 8'h99);
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    wait_txd_low(1'b0, "t6");
    repeat (38) @(negedge clk);
    check("t6_pre_txd",   32'(a_txd),      32'd0);
    check("t6_pre_level", 32'(a_tx_level), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_txd",      32'(a_txd),      32'd1);
    check("t6_rst_tx_level", 32'(a_tx_level), 32'd0);
    check("t6_rst_rx_level", 32'(a_rx_level), 32'd0);
    check("t6_rst_tx_ready", 32'(a_tx_ready), 32'd1);
    check("t6_rst_tx_idle",  32'(a_tx_idle),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    push(1'b0, 8'h3C);
    expect_rx(1'b0, 8'h3C, 1'b0, 1'b0, "t6_rx");
    repeat (200) @(negedge clk);
    check("t6_no_stale", 32'(a_rx_valid), 32'd0);
    check("t6_idle",     32'(a_tx_idle),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
